// File: rtl/fetch_queue_unit.sv
// Multi-issue fetch stage: fetches FETCH_W words per cycle into a DEPTH-entry instruction queue.
// Latency: a bundle fetched in cycle N is visible on instr_o/pc_o in cycle N+1.
// Backpressure: fetch stalls (PC held) while free space < FETCH_W; decode pops up to FETCH_W via deq_count_i.
module fetch_queue_unit #(
  parameter int          FETCH_W  = 2,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        en,
  input  logic                                        flush_i,
  input  logic [31:0]                                 flush_pc_i,
  input  logic                                        ex_redirect_i,
  input  logic [31:0]                                 ex_target_i,
  input  logic                                        pred_redirect_i,
  input  logic [((FETCH_W > 1) ? $clog2(FETCH_W) : 1)-1:0] pred_slot_i,
  input  logic [31:0]                                 pred_target_i,
  output logic [31:0]                                 imem_addr_o,
  input  logic [32*FETCH_W-1:0]                       imem_rdata_i,
  output logic [32*FETCH_W-1:0]                       instr_o,
  output logic [32*FETCH_W-1:0]                       pc_o,
  output logic [FETCH_W-1:0]                          valid_o,
  input  logic [$clog2(FETCH_W+1)-1:0]                deq_count_i,
  output logic [$clog2(DEPTH+1)-1:0]                  count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_mem_q [DEPTH];
  logic [31:0]      pc_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             fetch_fire;
  logic [CNT_W-1:0] deq_ext;
  logic [CNT_W-1:0] pred_n;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] pop_n;
  logic [31:0]      pc_next;

  // Resolve redirect priority, push/pop amounts and next PC for this cycle.
  always_comb begin
    redirect    = flush_i | ex_redirect_i;
    redirect_pc = flush_i ? flush_pc_i : ex_target_i;
    // Free space is judged on pre-pop occupancy so a same-cycle pop never enables a push.
    fetch_fire  = en & ~redirect & ((CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W));
    deq_ext     = CNT_W'(deq_count_i);
    pred_n      = CNT_W'(pred_slot_i) + CNT_W'(1);
    // Non-power-of-two FETCH_W leaves slot encodings past the bundle; clamp them.
    if (pred_n > CNT_W'(FETCH_W)) begin
      pred_n = CNT_W'(FETCH_W);
    end
    push_n  = '0;
    pop_n   = '0;
    pc_next = pc_q;
    if (redirect) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else begin
      pop_n = (deq_ext < count_q) ? deq_ext : count_q;
      if (fetch_fire && pred_redirect_i) begin
        push_n  = pred_n;
        pc_next = {pred_target_i[31:2], 2'b00};
      end else if (fetch_fire) begin
        push_n  = CNT_W'(FETCH_W);
        pc_next = pc_q + 32'(4 * FETCH_W);
      end
    end
  end

  // PC, queue pointers and occupancy; a redirect empties the queue by collapsing head onto tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      pc_q    <= pc_next;
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      pc_q    <= pc_next;
      head_q  <= head_q + PTR_W'(pop_n);
      tail_q  <= tail_q + PTR_W'(push_n);
      count_q <= count_q - pop_n + push_n;
    end
  end

  // Write the first push_n slots of the fetched bundle with their PCs at the tail.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (CNT_W'(k) < push_n) begin
          instr_q[tail_q + PTR_W'(k)]  <= imem_rdata_i[32*k +: 32];
          pc_mem_q[tail_q + PTR_W'(k)] <= pc_q + 32'(4 * k);
        end
      end
    end
  end

  for (genvar k = 0; k < FETCH_W; k++) begin : g_head
    assign instr_o[32*k +: 32] = instr_q[head_q + PTR_W'(k)];
    assign pc_o[32*k +: 32]    = pc_mem_q[head_q + PTR_W'(k)];
    assign valid_o[k]          = (count_q > CNT_W'(k));
  end

  assign imem_addr_o = pc_q;
  assign count_o     = count_q;

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised multi-issue fetch stage for the superscalar core. Each cycle it fetches FETCH_W consecutive instructions from instruction memory into a DEPTH-entry instruction queue. It handles redirects with fixed priority: mispredict flush first, then execute redirect, then predictor redirect. Decode drains up to FETCH_W entries per cycle through a count-based handshake.

Parameters:
FETCH_W, 2, instructions fetched per cycle and queue read-port width (1..4)
DEPTH, 8, queue entries; power of two, >= 2*FETCH_W
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  fetch enable; low freezes PC and blocks pushes
flush_i  in  1  mispredict recovery; highest priority
flush_pc_i  in  32  recovery target
ex_redirect_i  in  1  execute-stage jump/branch redirect
ex_target_i  in  32  execute redirect target
pred_redirect_i  in  1  predictor taken within current fetch bundle
pred_slot_i  in  $clog2(FETCH_W) (min 1)  slot index of the predicted-taken instruction
pred_target_i  in  32  predicted target
imem_addr_o  out  32  fetch address (equals pc_q)
imem_rdata_i  in  32*FETCH_W  combinational read; slot k holds the word at imem_addr_o+4k
instr_o  out  32*FETCH_W  queue head entries; slot 0 is oldest
pc_o  out  32*FETCH_W  PC of each head entry
valid_o  out  FETCH_W  bit k set iff count_q > k
deq_count_i  in  $clog2(FETCH_W+1)  entries decode consumes this cycle
count_o  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: pc_q=RESET_PC, head/tail/count=0, valid_o=0. Reset overrides every other input in the same cycle.
- Storage is registered. instr_o, pc_o and valid_o are combinational from head and count. imem_addr_o=pc_q.
- fetch_fire = en & ~flush_i & ~ex_redirect_i & (DEPTH-count_q >= FETCH_W).
  - Free space uses pre-pop occupancy. A same-cycle pop does not enable a push.
- Pop: pop_n = min(deq_count_i, count_q). Excess requests are silently clipped.
  - Pop applies regardless of en.
  - Pop is ignored on a flush or redirect cycle.
- Priority for each cycle, first match wins:
  1. flush_i: queue cleared (count=0, head=tail), pc_q<=flush_pc_i, no push.
  2. ex_redirect_i: identical action using ex_target_i.
  3. fetch_fire & pred_redirect_i: push slots 0..pred_slot_i only; pc_q<=pred_target_i.
  4. fetch_fire: push all FETCH_W slots; pc_q<=pc_q+4*FETCH_W.
  5. Otherwise: pc_q holds, no push.
- pred_redirect_i without fetch_fire is ignored. The predictor re-evaluates on the held PC next cycle.
- All loaded targets have bits [1:0] forced to 0. PC arithmetic is mod 2^32 and wraps with no flag.
- Pushed entry k stores {imem_rdata_i slot k, pc_q+4k}. Tail advances by the push count.
- Pointers are log2(DEPTH) bits and wrap naturally.
- count_next = count_q - pop_n + push_n. This never exceeds DEPTH, guaranteed by the free-space rule.
- Latency: an instruction fetched in cycle N appears on instr_o in cycle N+1 at the earliest.
- Full: the fetch stalls while free space is below FETCH_W. Empty: valid_o=0, and instr_o/pc_o are don't-care.

Test Plan:
(FETCH_W=2, DEPTH=8 for all scenarios.)
1. Fill: reset, then en=1, deq_count_i=0.
   - Pushes land at 0x0/0x4, 0x8/0xC, 0x10/0x14, 0x18/0x1C.
   - After 4 cycles count_o=8, and imem_addr_o holds 0x20 while full.
2. Streaming: deq_count_i=2 every cycle from reset.
   - From cycle 1, count_o=2 and valid_o=2'b11.
   - pc_o walks {0x0,0x4}, {0x8,0xC}, … with no bubbles.
3. Priority: with count=6, assert flush_i (0x100), ex_redirect_i (0x200) and deq_count_i=2 together.
   - Next cycle count_o=0 and imem_addr_o=0x100.
   - The following cycle pc_o slot0=0x100.
4. Predict truncation: at pc_q=0x20, pred_redirect_i=1, pred_slot_i=0, pred_target_i=0x83.
   - Only 0x20 is pushed (count +1).
   - Next imem_addr_o=0x80, and the next bundle is 0x80/0x84.
5. Stall and clip: count=3, en=0 for 3 cycles, deq_count_i=2.
   - count_o goes 1 then 0 then 0, with no underflow.
   - imem_addr_o is unchanged throughout.
6. Reset mid-operation: count=5 and fetch active, assert rst.
   - Next cycle count_o=0, valid_o=0, imem_addr_o=RESET_PC.
